// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op encodings, state type and constants for the M-extension unit
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared shift-add multiply / restoring divide step engine on magnitudes
module muldiv_datapath (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        step,
    input  logic        div,
    input  logic [31:0] sr_init,
    input  logic [31:0] opd_init,
    output logic [63:0] acc,
    output logic [31:0] sr
);

    logic [31:0] opd;
    logic [32:0] msum;
    logic [32:0] trial;

    // multiply adds the operand into the upper half; divide trial-subtracts the divisor from the shifted remainder
    always_comb begin
        msum  = {1'b0, acc[63:32]} + {1'b0, sr[0] ? opd : 32'd0};
        trial = {acc[63:32], sr[31]} - {1'b0, opd};
    end

    // accumulator holds product (mul) or remainder in its upper half (div); sr holds multiplier or quotient
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
            sr  <= '0;
            opd <= '0;
        end else if (load) begin
            acc <= '0;
            sr  <= sr_init;
            opd <= opd_init;
        end else if (step) begin
            if (div) begin
                acc[63:32] <= trial[32] ? {acc[62:32], sr[31]} : trial[31:0];
                sr         <= {sr[30:0], ~trial[32]};
            end else begin
                acc <= {msum, acc[31:1]};
                sr  <= {1'b0, sr[31:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with FSM, sign handling and divide special cases
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            write_en_o
);

    localparam int CW = $clog2(ITER);

    muldiv_state_e  state;
    muldiv_op_e     op_q;
    logic [CW-1:0]  count;
    logic           neg_q;
    logic           special_q;
    logic [31:0]    spec_res_q;

    muldiv_op_e     op_in;
    logic           accept;
    logic           sa;
    logic           sb;
    logic [31:0]    mag_a;
    logic [31:0]    mag_b;
    logic           div_zero;
    logic           div_ovf;
    logic           is_rem;
    logic [31:0]    spec_in;
    logic [63:0]    acc;
    logic [31:0]    sr;
    logic [63:0]    prod;
    logic [31:0]    quo;
    logic [31:0]    rem;
    logic [31:0]    normal;

    // operand sign stripping and divide special-case detection on the incoming request
    always_comb begin
        op_in    = muldiv_op_e'(funct3_i);
        accept   = (state == IDLE) && start_i && !flush_i;
        sa       = (op_in == MULH || op_in == MULHSU || op_in == DIV || op_in == REM) && op_a_i[31];
        sb       = (op_in == MULH || op_in == DIV || op_in == REM) && op_b_i[31];
        mag_a    = sa ? -op_a_i : op_a_i;
        mag_b    = sb ? -op_b_i : op_b_i;
        is_rem   = funct3_i[2] && funct3_i[1];
        div_zero = funct3_i[2] && (op_b_i == 32'd0);
        div_ovf  = (op_in == DIV || op_in == REM) && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
        spec_in  = is_rem ? (div_zero ? op_a_i : 32'd0) : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
    end

    muldiv_datapath u_dp (
        .clk      (clk_i),
        .rstn     (rstn_i),
        .load     (accept),
        .step     ((state == CALC) && !flush_i),
        .div      (op_q[2]),
        .sr_init  (funct3_i[2] ? mag_a : mag_b),
        .opd_init (funct3_i[2] ? mag_b : mag_a),
        .acc      (acc),
        .sr       (sr)
    );

    // sign restoration and result selection, only driven during DONE
    always_comb begin
        prod       = neg_q ? -acc : acc;
        quo        = neg_q ? -sr : sr;
        rem        = neg_q ? -acc[63:32] : acc[63:32];
        normal     = !op_q[2] ? ((op_q == MUL) ? prod[31:0] : prod[63:32]) : (op_q[1] ? rem : quo);
        busy_o     = state != IDLE;
        done_o     = state == DONE;
        result_o   = done_o ? (special_q ? spec_res_q : normal) : 32'd0;
        write_en_o = done_o && (rd_addr_o != 5'd0);
    end

    // control FSM: accept in IDLE, iterate in CALC, single-cycle DONE; flush aborts to IDLE
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            op_q       <= MUL;
            count      <= '0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            rd_addr_o  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q       <= op_in;
                    rd_addr_o  <= rd_addr_i;
                    neg_q      <= is_rem ? sa : (sa ^ sb);
                    special_q  <= div_zero || div_ovf;
                    spec_res_q <= spec_in;
                    count      <= '0;
                    state      <= (div_zero || div_ovf) ? DONE : CALC;
                end
                CALC: begin
                    count <= count + 1'b1;
                    state <= flush_i ? IDLE : (count == CW'(ITER - 1)) ? DONE : CALC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_o;
    logic        write_en;

    int total = 0;
    int bad = 0;

    muldiv_unit dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .funct3_i   (funct3),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .rd_addr_i  (rd_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .rd_addr_o  (rd_addr_o),
        .write_en_o (write_en)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // issue one request and observe it; lat is the negedge index (1 = cycle after start edge) of done, -1 on timeout
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output logic [31:0] res, output logic we, output logic [4:0] rdo,
                          output logic clean);
        @(negedge clk);
        start = 1; funct3 = f; op_a = a; op_b = b; rd_addr = rd;
        @(posedge clk);
        #1 start = 0; op_a = 32'h5A5A_1234; op_b = 32'd0; rd_addr = 5'd31;
        lat = -1; res = 0; we = 0; rdo = 0; clean = 1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (!busy) clean = 0;
            if (done) begin
                lat = i; res = result; we = write_en; rdo = rd_addr_o;
            end else if (result !== 32'd0 || write_en !== 1'b0) clean = 0;
        end
        @(negedge clk);
        if (done || busy) clean = 0;
    endtask

    task automatic test_reset();
        rstn = 0; start = 0; flush = 0; funct3 = 0; op_a = 0; op_b = 0; rd_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if ({write_en, rd_addr_o} !== 6'd0) begin bad++; $display("FAIL reset_we_rd got=%b/%0d want=0/0", write_en, rd_addr_o); end
        rstn = 1;
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, res, we, rdo, clean);
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
        total++; if (res !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h want=ffffffeb", res); end
        total++; if (we !== 1'b1 || rdo !== 5'd5) begin bad++; $display("FAIL mul_write got=%b/%0d want=1/5", we, rdo); end
        total++; if (clean !== 1'b1) begin bad++; $display("FAIL mul_handshake got=%b want=1", clean); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  f [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] a [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] e [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], b[i], 5'd9, lat, res, we, rdo, clean);
            total++; if (res !== e[i] || lat !== 33) begin bad++; $display("FAIL mulh_%0d got=%h lat=%0d want=%h lat=33", i, res, lat, e[i]); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], 5'd3, lat, res, we, rdo, clean);
            total++; if (res !== e[i] || lat !== 33) begin bad++; $display("FAIL div_%0d got=%h lat=%0d want=%h lat=33", i, res, lat, e[i]); end
            total++; if (clean !== 1'b1) begin bad++; $display("FAIL div_handshake_%0d got=%b want=1", i, clean); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [3] = '{3'b101, 3'b110, 3'b100};
        logic [31:0] a [3] = '{32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] b [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] e [3] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], b[i], 5'd12, lat, res, we, rdo, clean);
            total++; if (res !== e[i] || lat !== 1) begin bad++; $display("FAIL special_%0d got=%h lat=%0d want=%h lat=1", i, res, lat, e[i]); end
            total++; if (clean !== 1'b1 || we !== 1'b1) begin bad++; $display("FAIL special_hs_%0d got=%b/%b want=1/1", i, clean, we); end
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        start = 1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_addr = 5'd4;
        @(posedge clk);
        #1 start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_prebusy got=%b want=1", busy); end
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b want=0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_nodone got=%0d want=0", seen); end
    endtask

    task automatic test_flush_start_idle();
        @(negedge clk);
        start = 1; flush = 1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_addr = 5'd1;
        @(posedge clk);
        #1 start = 0; flush = 0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_over_start got=%b want=0", busy); end
    endtask

    task automatic test_start_held();
        int lat = -1; logic [31:0] res = 0;
        @(negedge clk);
        start = 1; funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_addr = 5'd8;
        @(posedge clk);
        #1 op_a = 32'd100; op_b = 32'd100; funct3 = 3'b101;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (done) begin lat = i; res = result; start = 0; end
        end
        start = 0;
        total++; if (lat !== 33 || res !== 32'd42) begin bad++; $display("FAIL start_held got=%h lat=%0d want=0000002a lat=33", res, lat); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_held_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        start = 1; funct3 = 3'b011; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; rd_addr = 5'd17;
        @(posedge clk);
        #1 start = 0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rstn = 0;
        @(posedge clk);
        #1;
        total++; if ({busy, done, write_en, result, rd_addr_o} !== 40'd0) begin bad++; $display("FAIL reset_mid got=%b%b%b/%h/%0d want=all zero", busy, done, write_en, result, rd_addr_o); end
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid_nodone got=%0d want=0", seen); end
    endtask

    task automatic test_rd_zero();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        run_op(3'b000, 32'd3, 32'd4, 5'd0, lat, res, we, rdo, clean);
        total++; if (lat !== 33 || res !== 32'd12) begin bad++; $display("FAIL rd0_result got=%h lat=%0d want=0000000c lat=33", res, lat); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b want=0", we); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic we; logic [4:0] rdo; logic clean;
        run_op(3'b101, 32'd81, 32'd9, 5'd2, lat, res, we, rdo, clean);
        total++; if (res !== 32'd9 || lat !== 33) begin bad++; $display("FAIL b2b_first got=%h lat=%0d want=00000009 lat=33", res, lat); end
        run_op(3'b111, 32'd81, 32'd10, 5'd6, lat, res, we, rdo, clean);
        total++; if (res !== 32'd1 || rdo !== 5'd6) begin bad++; $display("FAIL b2b_second got=%h rd=%0d want=00000001 rd=6", res, rdo); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_flush_start_idle();
        test_start_held();
        test_reset_mid();
        test_rd_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
